// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg: shared vector writeback types, SEW/LMUL encodings and widths
package riscv_v_pkg;
  localparam int VLEN = 128;
  localparam int VLENB = VLEN / 8;
  localparam int BE_W = VLENB;
  localparam int VL_W = 8;
  typedef logic [4:0] riscv_v_rf_addr_t;
  typedef logic [VL_W-1:0] riscv_v_vl_t;
  typedef logic [VLEN-1:0] riscv_v_data_t;
  typedef logic [VLEN-1:0] riscv_v_mask_t;
  typedef logic [BE_W-1:0] riscv_v_rf_wr_en_t;
  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} riscv_v_sew_e;
  typedef enum logic [1:0] {LMUL1, LMUL2, LMUL4, LMUL8} riscv_v_lmul_e;
  typedef struct packed {
    riscv_v_rf_addr_t vd;
    riscv_v_lmul_e lmul;
    riscv_v_sew_e sew;
    riscv_v_vl_t vl;
    logic vm;
    riscv_v_data_t data;
  } riscv_v_beat_t;
endpackage

// File: rtl/riscv_v_wb_be_gen.sv
// riscv_v_wb_be_gen: per-byte write enables and fill data for one result beat (RISCV_V_WB_TAIL_AGNOSTIC_EN selects agnostic fill)
module riscv_v_wb_be_gen
  import riscv_v_pkg::*;
(
  input  logic [2:0]         k,
  input  riscv_v_sew_e       sew,
  input  riscv_v_vl_t        vl,
  input  logic               vm,
  input  riscv_v_mask_t      mask,
  input  riscv_v_data_t      data,
  output riscv_v_rf_wr_en_t  wr_en,
  output riscv_v_data_t      wb_data
);
  riscv_v_rf_wr_en_t act;
  for (genvar b = 0; b < BE_W; b++) begin : g_b
    logic [7:0] e;
    assign e = 8'({5'd0, k} << (3'd4 - {1'b0, sew})) + (8'(b) >> sew);
    assign act[b] = (e < vl) && (vm || (!e[7] && mask[e[6:0]]));
`ifdef RISCV_V_WB_TAIL_AGNOSTIC_EN
    assign wb_data[8*b+:8] = act[b] ? data[8*b+:8] : 8'hFF;
`else
    assign wb_data[8*b+:8] = data[8*b+:8];
`endif
  end
`ifdef RISCV_V_WB_TAIL_AGNOSTIC_EN
  assign wr_en = (vl != '0) ? '1 : '0;
`else
  assign wr_en = act;
`endif
endmodule

// File: rtl/riscv_v_rf_wb.sv
// riscv_v_rf_wb: buffered vector result writeback to the RF (RISCV_V_WB_TAIL_AGNOSTIC_EN selects agnostic fill)
module riscv_v_rf_wb
  import riscv_v_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               res_valid,
  output logic               res_ready,
  input  riscv_v_rf_addr_t   res_vd,
  input  logic [1:0]         res_lmul,
  input  logic [1:0]         res_sew,
  input  riscv_v_vl_t        res_vl,
  input  logic               res_vm,
  input  riscv_v_data_t      res_data,
  input  logic               wb_hold,
  input  riscv_v_mask_t      mask,
  output riscv_v_rf_addr_t   wr_addr,
  output riscv_v_data_t      data_in,
  output riscv_v_rf_wr_en_t  wr_en,
  output logic               busy
);
  localparam int PW = $clog2(BUF_DEPTH);
  typedef enum logic {IDLE, GROUP} state_e;
  state_e state, state_n;
  riscv_v_beat_t buf_q [BUF_DEPTH];
  riscv_v_beat_t head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] cnt;
  logic [2:0] beat_cnt, beat_cnt_n;
  logic push, pop, last;
  riscv_v_rf_addr_t g_vd, cur_vd;
  riscv_v_lmul_e g_lmul, cur_lmul;
  riscv_v_sew_e g_sew, cur_sew;
  riscv_v_vl_t g_vl, cur_vl;
  logic g_vm, cur_vm;
  riscv_v_rf_wr_en_t be;
  riscv_v_data_t wb_data;
  assign res_ready = rst_n && (cnt != (PW+1)'(BUF_DEPTH));
  assign push = res_valid && res_ready;
  assign pop = (cnt != '0) && !wb_hold;
  assign head = buf_q[rd_ptr];
  assign cur_vd = (state == IDLE) ? head.vd : g_vd;
  assign cur_lmul = (state == IDLE) ? head.lmul : g_lmul;
  assign cur_sew = (state == IDLE) ? head.sew : g_sew;
  assign cur_vl = (state == IDLE) ? head.vl : g_vl;
  assign cur_vm = (state == IDLE) ? head.vm : g_vm;
  assign last = beat_cnt == 3'((4'd1 << cur_lmul) - 4'd1);
  assign busy = (state == GROUP) || (cnt != '0);
  riscv_v_wb_be_gen u_be_gen (
    .k       (beat_cnt),
    .sew     (cur_sew),
    .vl      (cur_vl),
    .vm      (cur_vm),
    .mask    (mask),
    .data    (head.data),
    .wr_en   (be),
    .wb_data (wb_data)
  );
  // group sequencing: advance beat index on each pop, return to IDLE after the last beat
  always_comb begin
    state_n = pop ? (last ? IDLE : GROUP) : state;
    beat_cnt_n = pop ? (last ? 3'd0 : beat_cnt + 3'd1) : beat_cnt;
  end
  // result-beat FIFO; no fall-through, a pushed beat is visible next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= '{vd: res_vd, lmul: riscv_v_lmul_e'(res_lmul), sew: riscv_v_sew_e'(res_sew),
                           vl: res_vl, vm: res_vm, data: res_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // state register and group parameters captured on the first beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      beat_cnt <= beat_cnt_n;
      if (pop && state == IDLE) begin
        g_vd <= head.vd;
        g_lmul <= head.lmul;
        g_sew <= head.sew;
        g_vl <= head.vl;
        g_vm <= head.vm;
      end
    end
  end
  // registered RF write port; address and data hold between pops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en <= '0;
      wr_addr <= '0;
      data_in <= '0;
    end else begin
      wr_en <= pop ? be : '0;
      if (pop) begin
        wr_addr <= cur_vd + 5'(beat_cnt);
        data_in <= wb_data;
      end
    end
  end
endmodule

// File: doc/riscv_v_rf_wb.md
RISCV_V_RF_WB -- requirements
Module: riscv_v_rf_wb

Interface
REQ-001 Parameter: BUF_DEPTH, default 2, depth of the result-beat buffer (power of 2, >=2).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: res_valid  input  1  result beat valid.
REQ-005 Port: res_ready  output  1  beat accepted when res_valid&&res_ready.
REQ-006 Port: res_vd  input  riscv_v_rf_addr_t  base destination register, sampled on a group's first beat.
REQ-007 Port: res_lmul  input  2  log2 group size (0..3 -> 1,2,4,8 beats), sampled on first beat.
REQ-008 Port: res_sew  input  2  element width 0..3 -> 8/16/32/64 bit, sampled on first beat.
REQ-009 Port: res_vl  input  riscv_v_vl_t  active element count, sampled on first beat.
REQ-010 Port: res_vm  input  1  1 = unmasked, sampled on first beat.
REQ-011 Port: res_data  input  riscv_v_data_t  one full register of result data per beat.
REQ-012 Port: wb_hold  input  1  stall: no RF write issued while high.
REQ-013 Port: mask  input  riscv_v_mask_t  v0 mask bits from the register file.
REQ-014 Port: wr_addr  output  riscv_v_rf_addr_t  RF write address.
REQ-015 Port: data_in  output  riscv_v_data_t  RF write data.
REQ-016 Port: wr_en  output  riscv_v_rf_wr_en_t  RF per-byte write enable.
REQ-017 Port: busy  output  1  group in progress or buffer non-empty.

Function
REQ-018 Accepted beats enter a BUF_DEPTH FIFO; res_ready = !full, so a beat is accepted on the cycle full deasserts.
REQ-019 FSM states IDLE and GROUP; IDLE->GROUP when head beat pops with beat_cnt==0 and lmul>0; GROUP->IDLE when the beat with beat_cnt==2^lmul-1 pops.
REQ-020 Head pops when FIFO non-empty and wb_hold==0; one pop per cycle max.
REQ-021 Pop of beat k writes wr_addr = vd+k (modulo 32), data_in = beat data, registered; latency = 1 cycle from pop to wr_en.
REQ-022 Element e = k*(VLEN/SEW)+i is active iff e < vl and (vm or mask[e]); mask bits at index >= mask width read as 0.
REQ-023 All SEW/8 bytes of an active element have wr_en=1; inactive element bytes per REQ-031.
REQ-024 vl=0: beats are consumed, wr_en=0 for whole group (undisturbed mode).
REQ-025 Non-pop cycles drive wr_en=0; wr_addr/data_in hold last value.
REQ-026 wb_hold mid-group freezes beat_cnt and FSM; resumes at same k.
REQ-027 Simultaneous push and pop while full: push refused (ready low that cycle); while empty: no fall-through, beat appears one cycle later.
REQ-028 busy = (state==GROUP) || !empty.

Reset
REQ-029 rst_n low at a clock edge: FIFO empty, state IDLE, beat_cnt=0, wr_en=0, wr_addr=0, data_in=0, res_ready=0 during reset, 1 the cycle after.
REQ-030 Reset mid-group discards all buffered beats and the partial group; no further writes for it.

Configuration
REQ-031 Macro RISCV_V_WB_TAIL_AGNOSTIC_EN: defined -> inactive element bytes have wr_en=1 with data 0xFF; undefined -> inactive bytes have wr_en=0 (undisturbed).

Structure
REQ-032 riscv_v_pkg holds riscv_v_vl_t, SEW/LMUL encodings, and the byte-enable width constant.
REQ-033 Byte-enable generation is sub-module riscv_v_wb_be_gen (combinational: k, sew, vl, vm, mask -> wr_en).

Verification
REQ-034 Reset, lmul=0, sew=8, vl=VLEN/8, vm=1, vd=5 -> next-cycle wr_addr=5, wr_en all ones.
REQ-035 sew=32, vl=3, vm=1 -> only bytes 0..11 enabled; with macro, all bytes enabled, bytes 12+ =0xFF.
REQ-036 lmul=2, vd=8, 4 beats, wb_hold high 3 cycles after beat 1 -> writes to 8,9,10,11 in order, none during hold.
REQ-037 sew=8, vm=0, mask=0x...A5 -> byte enables equal mask pattern 0xA5 in low byte.
REQ-038 wb_hold held, push 3 beats with BUF_DEPTH=2 -> res_ready low after 2nd; release -> 3rd accepted, all written.
REQ-039 rst_n low during beat 2 of lmul=3 group -> wr_en=0, busy=0 after reset, no remaining writes.
